// File: rtl/trng_collector.sv
// trng_collector
//   Multi-channel entropy collector for the ring-oscillator random source.
//   Each ring-oscillator output is brought into the clk domain through a
//   two-flop synchroniser. The enabled channels are XOR-combined into one raw
//   bit, which is sampled once every SAMPLE_DIV cycles while en=1. Each sample
//   either goes straight into the byte packer (debias=0) or through a von
//   Neumann pair filter (debias=1). Completed bytes, first sampled bit in the
//   MSB, are queued in a small first-word-fall-through FIFO.
//
//   Optional build macro: HEALTH_TEST_EN adds a repetition-count test on the
//   raw sample stream. Without it, health_fail is tied to 0.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ro_in        raw ring-oscillator outputs, asynchronous to clk
//   ch_en        per-channel enable mask (synchronous)
//   en           collector enable; when low the sample counter holds at 0
//   debias       1 = von Neumann debiasing, 0 = raw XOR bits
//   clr          synchronous clear of FIFO, bit count, pair state and flags
//   data         FIFO head byte (0 when empty)
//   valid        FIFO non-empty
//   ready        consumer accepts data when valid & ready
//   overflow     sticky: a completed byte was dropped because the FIFO was full
//   health_fail  sticky repetition-count failure
module trng_collector #(
    parameter int unsigned NUM_RO     = 4,
    parameter int unsigned SAMPLE_DIV = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RCT_LIMIT  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_RO-1:0] ro_in,
    input  logic [NUM_RO-1:0] ch_en,
    input  logic              en,
    input  logic              debias,
    input  logic              clr,
    output logic [7:0]        data,
    output logic              valid,
    input  logic              ready,
    output logic              overflow,
    output logic              health_fail
);

    localparam int unsigned CW = $clog2(SAMPLE_DIV);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_DIV - 1);

    if (NUM_RO == 0 || NUM_RO > 8 || SAMPLE_DIV < 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || RCT_LIMIT < 2) begin : g_param_check
        $error("trng_collector: illegal parameter value");
    end

    typedef enum logic {
        PAIR_A,
        PAIR_B
    } pair_state_e;

    logic [NUM_RO-1:0] sync1_q, sync1_d;
    logic [NUM_RO-1:0] sync2_q, sync2_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    pair_state_e       pair_q, pair_d;
    logic              pair_bit_q, pair_bit_d;
    logic              debias_prev_q, debias_prev_d;
    // Only the seven most recent bits are kept; the eighth is taken straight
    // from the emitting bit when the byte is pushed.
    logic [6:0]        shift_q, shift_d;
    logic [3:0]        bcnt_q, bcnt_d;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;

    logic              raw_bit;
    logic              tick;
    logic              emit;
    logic              emit_bit;
    logic              byte_done;
    logic [7:0]        push_byte;
    logic              push_req;
    logic              push_block;
    logic              do_push;
    logic              do_pop;
    logic              fifo_empty;
    logic              fifo_full;

    always_comb begin
        sync1_d = ro_in;
        sync2_d = sync1_q;
        raw_bit = ^(sync2_q & ch_en);
        tick    = en && (cnt_q == CNT_MAX);

        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Bit source: raw samples directly, or von Neumann pairs. A change of
    // mode abandons any half-collected pair but leaves the partial byte alone.
    always_comb begin
        pair_d        = pair_q;
        pair_bit_d    = pair_bit_q;
        debias_prev_d = debias;
        emit          = 1'b0;
        emit_bit      = 1'b0;

        if (tick && !debias) begin
            emit     = 1'b1;
            emit_bit = raw_bit;
        end

        if (debias != debias_prev_q) begin
            pair_d = PAIR_A;
        end else if (tick && debias) begin
            case (pair_q)
                PAIR_A: begin
                    pair_bit_d = raw_bit;
                    pair_d     = PAIR_B;
                end
                PAIR_B: begin
                    pair_d = PAIR_A;
                    // 01 emits 0, 10 emits 1: the first bit of a differing pair
                    if (pair_bit_q != raw_bit) begin
                        emit     = 1'b1;
                        emit_bit = pair_bit_q;
                    end
                end
                default: pair_d = PAIR_A;
            endcase
        end

        if (clr) begin
            pair_d = PAIR_A;
        end
    end

    // Byte packer and FIFO.
    always_comb begin
        shift_d   = shift_q;
        bcnt_d    = bcnt_q;
        byte_done = 1'b0;
        push_byte = {shift_q, emit_bit};

        if (emit) begin
            shift_d = {shift_q[5:0], emit_bit};
            if (bcnt_q == 4'd7) begin
                bcnt_d    = '0;
                byte_done = 1'b1;
            end else begin
                bcnt_d = bcnt_q + 4'd1;
            end
        end

        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
        valid      = !fifo_empty;
        data       = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

        do_pop   = valid && ready;
        push_req = byte_done && !push_block;
        // When full, a simultaneous pop frees the head slot, which is the
        // very slot the write pointer addresses.
        do_push  = push_req && (!fifo_full || do_pop);

        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_byte;
        end
        wr_ptr_d   = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d   = rd_ptr_q + (AW+1)'(do_pop);
        overflow_d = overflow_q | (push_req && fifo_full && !do_pop);

        if (clr) begin
            bcnt_d     = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
        end
    end

    assign overflow = overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            cnt_q         <= '0;
            pair_q        <= PAIR_A;
            pair_bit_q    <= 1'b0;
            debias_prev_q <= 1'b0;
            shift_q       <= '0;
            bcnt_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            overflow_q    <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            cnt_q         <= cnt_d;
            pair_q        <= pair_d;
            pair_bit_q    <= pair_bit_d;
            debias_prev_q <= debias_prev_d;
            shift_q       <= shift_d;
            bcnt_q        <= bcnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            overflow_q    <= overflow_d;
            mem_q         <= mem_d;
        end
    end

`ifdef HEALTH_TEST_EN
    localparam int unsigned RW = $clog2(RCT_LIMIT + 1);
    localparam logic [RW-1:0] RCT_MAX = RW'(RCT_LIMIT);

    logic [RW-1:0] rct_cnt_q, rct_cnt_d;
    logic          rct_bit_q, rct_bit_d;
    logic          health_fail_q, health_fail_d;
    logic          rct_hit;

    // Run length of identical raw samples, saturating at the limit. A count
    // of 0 means no sample has been seen since reset.
    always_comb begin
        rct_cnt_d = rct_cnt_q;
        rct_bit_d = rct_bit_q;
        rct_hit   = 1'b0;
        if (tick) begin
            rct_bit_d = raw_bit;
            if (rct_cnt_q != '0 && raw_bit == rct_bit_q) begin
                if (rct_cnt_q != RCT_MAX) begin
                    rct_cnt_d = rct_cnt_q + RW'(1);
                end
            end else begin
                rct_cnt_d = RW'(1);
            end
            rct_hit = (rct_cnt_d == RCT_MAX);
        end
        health_fail_d = clr ? 1'b0 : (health_fail_q | rct_hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rct_cnt_q     <= '0;
            rct_bit_q     <= 1'b0;
            health_fail_q <= 1'b0;
        end else begin
            rct_cnt_q     <= rct_cnt_d;
            rct_bit_q     <= rct_bit_d;
            health_fail_q <= health_fail_d;
        end
    end

    // The byte completing on the failing sample is already suspect.
    assign push_block  = health_fail_q | rct_hit;
    assign health_fail = health_fail_q;
`else
    assign push_block  = 1'b0;
    assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_trng_collector.sv
module tb_trng_collector;

    localparam int unsigned NUM_RO = 4;
    localparam int unsigned DIV    = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned RCT    = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_RO-1:0] ro_in;
    logic [NUM_RO-1:0] ch_en;
    logic              en;
    logic              debias;
    logic              clr;
    logic [7:0]        data;
    logic              valid;
    logic              ready;
    logic              overflow;
    logic              health_fail;

    trng_collector #(
        .NUM_RO     (NUM_RO),
        .SAMPLE_DIV (DIV),
        .FIFO_DEPTH (DEPTH),
        .RCT_LIMIT  (RCT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ro_in       (ro_in),
        .ch_en       (ch_en),
        .en          (en),
        .debias      (debias),
        .clr         (clr),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .overflow    (overflow),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called just after a clock edge with the sample counter at 0: holds
    // the inputs for one full sample period, ending just after the tick edge.
    task automatic tick_bits(input logic [NUM_RO-1:0] ro, input logic [NUM_RO-1:0] ch,
                             input bit pop_at_tick);
        ro_in = ro;
        ch_en = ch;
        repeat (DIV - 1) @(posedge clk);
        #1;
        if (pop_at_tick) ready = 1'b1;
        @(posedge clk);
        #1;
        if (pop_at_tick) ready = 1'b0;
    endtask

    // Channel 0 only; the masked channels carry noise that must not leak in.
    task automatic send_bit(input logic b, input bit pop_at_tick);
        logic [NUM_RO-1:0] r;
        r    = NUM_RO'($urandom);
        r[0] = b;
        tick_bits(r, NUM_RO'(1), pop_at_tick);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit pop_last);
        for (int i = 7; i >= 0; i--) send_bit(b[i], pop_last && (i == 0));
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        check({name, " valid"}, 32'(valid), 32'(1));
        check({name, " data"}, 32'(data), 32'(exp));
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model: sample stream -> emitted bits -> bytes, MSB first.
    logic [7:0]  m_acc;
    int unsigned m_n;
    bit          m_pend;
    logic        m_first;
    logic [7:0]  expq[$];
    logic [7:0]  gotq[$];
    bit          mon_on = 1'b0;

    task automatic model_emit(input logic b);
        m_acc = {m_acc[6:0], b};
        m_n++;
        if (m_n == 8) begin
            expq.push_back(m_acc);
            m_n = 0;
        end
    endtask

    task automatic model_sample(input logic b, input logic mode);
        if (!mode) model_emit(b);
        else if (!m_pend) begin
            m_pend  = 1'b1;
            m_first = b;
        end else begin
            m_pend = 1'b0;
            if (m_first != b) model_emit(m_first);
        end
    endtask

    always @(negedge clk) if (mon_on && valid && ready) gotq.push_back(data);

    typedef struct {
        logic        mode;
        logic [31:0] bits;
        int          nbits;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [7:0]        ovf_bytes[5];
        logic [NUM_RO-1:0] r, c;
        logic              b;
        int unsigned       k;

        tbl[0] = '{1'b0, 32'h0000_00AC, 8,  8'hAC};
        tbl[1] = '{1'b0, 32'h0000_00FF, 8,  8'hFF};
        tbl[2] = '{1'b0, 32'h0000_0001, 8,  8'h01};
        tbl[3] = '{1'b1, 32'h006C_9B26, 24, 8'h6D};  // 01,10,11,00,10 repeated
        tbl[4] = '{1'b1, 32'h0000_AAAA, 16, 8'hFF};
        tbl[5] = '{1'b1, 32'h0000_55AA, 16, 8'h0F};
        ovf_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        rst_n  = 1'b0;
        en     = 1'b0;
        debias = 1'b0;
        clr    = 1'b0;
        ready  = 1'b0;
        ro_in  = '0;
        ch_en  = '0;
        #2;
        check("reset valid", 32'(valid), 32'(0));
        check("reset data", 32'(data), 32'(0));
        check("reset overflow", 32'(overflow), 32'(0));
        check("reset health_fail", 32'(health_fail), 32'(0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven single-byte vectors.
        for (int t = 0; t < 6; t++) begin
            debias = tbl[t].mode;
            en     = 1'b1;
            for (int i = tbl[t].nbits - 1; i >= 0; i--) begin
                if (i == 0) check($sformatf("vec%0d early valid", t), 32'(valid), 32'(0));
                send_bit(tbl[t].bits[i], 1'b0);
            end
            en = 1'b0;
            pop_check($sformatf("vec%0d", t), tbl[t].exp);
            check($sformatf("vec%0d empty after pop", t), 32'(valid), 32'(0));
        end

        // Overflow: five bytes into a four-entry FIFO with no consumer.
        debias = 1'b0;
        en     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_byte(ovf_bytes[i], 1'b0);
            if (i == 3) begin
                check("full overflow", 32'(overflow), 32'(0));
                check("full head", 32'(data), 32'(8'h11));
            end
        end
        en = 1'b0;
        check("ovf flag", 32'(overflow), 32'(1));
        check("ovf head", 32'(data), 32'(8'h11));
        check("ovf valid", 32'(valid), 32'(1));
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr valid", 32'(valid), 32'(0));
        check("clr overflow", 32'(overflow), 32'(0));
        check("clr data", 32'(data), 32'(0));

        // Full FIFO with a pop on the same edge as the next push.
        en = 1'b1;
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        send_byte(8'hA3, 1'b0);
        send_byte(8'hA4, 1'b0);
        send_byte(8'hA5, 1'b1);
        en = 1'b0;
        check("push+pop overflow", 32'(overflow), 32'(0));
        pop_check("push+pop 0", 8'hA2);
        pop_check("push+pop 1", 8'hA3);
        pop_check("push+pop 2", 8'hA4);
        pop_check("push+pop 3", 8'hA5);
        check("push+pop empty", 32'(valid), 32'(0));

        // Asynchronous reset in the middle of a byte.
        en = 1'b1;
        send_byte(8'h5A, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst valid", 32'(valid), 32'(0));
        check("async rst data", 32'(data), 32'(0));
        check("async rst overflow", 32'(overflow), 32'(0));
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        en    = 1'b1;
        send_byte(8'h3C, 1'b0);
        en = 1'b0;
        pop_check("post-reset byte", 8'h3C);
        check("post-reset empty", 32'(valid), 32'(0));

`ifdef HEALTH_TEST_EN
        apply_reset();
        ready = 1'b1;
        en    = 1'b1;
        for (int i = 0; i < 31; i++) tick_bits('0, NUM_RO'(1), 1'b0);
        check("rct below limit", 32'(health_fail), 32'(0));
        tick_bits('0, NUM_RO'(1), 1'b0);
        check("rct at limit", 32'(health_fail), 32'(1));
        ready = 1'b0;
        for (int i = 0; i < 8; i++) tick_bits('0, NUM_RO'(1), 1'b0);
        check("rct blocks push", 32'(valid), 32'(0));
        en  = 1'b0;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("rct clr", 32'(health_fail), 32'(0));
`else
        check("health_fail tied low", 32'(health_fail), 32'(0));
`endif

        // Randomised run against the reference model, consumer always ready.
        apply_reset();
        m_acc  = '0;
        m_n    = 0;
        m_pend = 1'b0;
        debias = 1'b0;
        ready  = 1'b1;
        mon_on = 1'b1;
        en     = 1'b1;
        for (int p = 0; p < 300; p++) begin
            if ($urandom_range(15) == 0) begin
                debias = ~debias;
                m_pend = 1'b0;
            end
            if ($urandom_range(9) == 0) begin
                en = 1'b0;
                k  = $urandom_range(3, 1);
                repeat (k) @(posedge clk);
                #1;
                en = 1'b1;
            end
            r = NUM_RO'($urandom);
            c = NUM_RO'($urandom);
            b = ($countones(r & c) % 2) == 1;
            tick_bits(r, c, 1'b0);
            model_sample(b, debias);
        end
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mon_on = 1'b0;
        check("rand byte count", 32'(gotq.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < gotq.size(); i++)
            check($sformatf("rand byte %0d", i), 32'(gotq[i]), 32'(expq[i]));
        check("rand overflow", 32'(overflow), 32'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
